// File: rtl/logic_function_stream_8bit_if.sv
// Operand/result stream interface for logic_function_stream_8bit.
// Carries the byte-serial operand input stream and the result output stream.
// master: operand source plus result consumer. slave: the function block.
interface logic_function_stream_8bit_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_first;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output in_first,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_first,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/logic_function_stream_8bit.sv
// Sequential front end for Y = (A & B) | ((C ^ D) & E) | ((F ^ G) & H).
// Eight operand bytes arrive on a valid/ready stream in the order A..H.
// Y is registered in a single EVAL cycle and then held on the result stream
// until the consumer takes it.
// Optional macro LFS_RESULT_COUNT_EN adds a 16-bit wrapping counter of
// accepted results on port result_count.
module logic_function_stream_8bit #(
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    logic_function_stream_8bit_if.slave   bus,
    output logic                          frame_err,
    output logic                          busy
`ifdef LFS_RESULT_COUNT_EN
    ,
    output logic [15:0]                   result_count
`endif
);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]        r_state;
    logic [2:0]        r_idx;
    logic [DATA_W-1:0] r_ops [0:7];
    logic [DATA_W-1:0] r_out_data;
    logic              r_frame_err;

    logic              w_in_acc;
    logic              w_out_acc;
    logic [DATA_W-1:0] w_y;

    // Handshake qualifiers and the bitwise result from the operand registers
    always_comb begin
        w_in_acc  = bus.in_valid  && (r_state == S_LOAD);
        w_out_acc = bus.out_ready && (r_state == S_OUT);
        w_y       = (r_ops[0] & r_ops[1])
                  | ((r_ops[2] ^ r_ops[3]) & r_ops[4])
                  | ((r_ops[5] ^ r_ops[6]) & r_ops[7]);
    end

    // Frame loading, evaluation and result hand-off state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_frame_err <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                r_ops[i] <= '0;
            end
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_in_acc) begin
                        if (bus.in_first && (r_idx != 3'd0)) begin
                            // Resync: drop the partial frame, restart at operand A
                            r_ops[0]    <= bus.in_data;
                            r_idx       <= 3'd1;
                            r_frame_err <= 1'b1;
                        end else begin
                            r_ops[r_idx] <= bus.in_data;
                            if (r_idx == 3'd7) begin
                                r_idx   <= '0;
                                r_state <= S_EVAL;
                            end else begin
                                r_idx <= r_idx + 3'd1;
                            end
                        end
                    end
                end
                S_EVAL: begin
                    r_out_data <= w_y;
                    r_state    <= S_OUT;
                end
                S_OUT: begin
                    if (w_out_acc) begin
                        r_idx   <= '0;
                        r_state <= S_LOAD;
                    end
                end
                default: begin
                    r_idx   <= '0;
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

`ifdef LFS_RESULT_COUNT_EN
    logic [15:0] r_result_count;

    // Count accepted results; wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result_count <= '0;
        end else if (w_out_acc) begin
            r_result_count <= r_result_count + 16'd1;
        end
    end

    assign result_count = r_result_count;
`endif

    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.out_data  = r_out_data;
    assign frame_err     = r_frame_err;
    assign busy          = (r_state != S_LOAD) || (r_idx != 3'd0);

endmodule

// File: tb/tb_logic_function_stream_8bit.sv
// Directed, table-driven bench for logic_function_stream_8bit.
// Inputs change and outputs are sampled on the falling edge of clk.
// Define LFS_RESULT_COUNT_EN to also exercise the result counter.
module tb_logic_function_stream_8bit;

    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;
    logic frame_err;
    logic busy;
`ifdef LFS_RESULT_COUNT_EN
    logic [15:0] result_count;
    logic [15:0] exp_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic_function_stream_8bit_if #(.DATA_W(DATA_W)) bus ();

    logic_function_stream_8bit #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .frame_err    (frame_err),
        .busy         (busy)
`ifdef LFS_RESULT_COUNT_EN
        ,
        .result_count (result_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] ops;   // {H,G,F,E,D,C,B,A}, A in the low byte
        logic        first; // drive in_first on operand A
        logic        gap;   // idle cycle after operand D
        logic [7:0]  y;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic f);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_first = f;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
    endtask

    // Drives one full frame; returns at the falling edge after the 8th beat
    task automatic send_frame(input logic [63:0] ops, input logic first, input logic gap);
        logic err_seen;
        err_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat(ops[i*8 +: 8], (i == 0) ? first : 1'b0);
            err_seen |= frame_err;
            if (i == 1) chk("busy_mid_frame", busy, 1);
            if (gap && (i == 3)) begin
                idle();
                err_seen |= frame_err;
            end
        end
        idle();
        err_seen |= frame_err;
        chk("frame_err_quiet", err_seen, 0);
        chk("early_out_valid", bus.out_valid, 0);
        chk("eval_in_ready", bus.in_ready, 0);
    endtask

    // Checks the result one cycle later; completes the hand-off if out_ready
    task automatic get_result(input logic [7:0] y);
        @(negedge clk);
        chk("out_valid_high", bus.out_valid, 1);
        chk("out_data", bus.out_data, y);
        chk("out_in_ready", bus.in_ready, 0);
        if (bus.out_ready) begin
            @(negedge clk);
`ifdef LFS_RESULT_COUNT_EN
            exp_count++;
            chk("result_count", result_count, exp_count);
`endif
            chk("out_valid_one_cycle", bus.out_valid, 0);
            chk("ready_after_result", bus.in_ready, 1);
            chk("idle_busy", busy, 0);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
`ifdef LFS_RESULT_COUNT_EN
        exp_count = '0;
        chk("rst_result_count", result_count, exp_count);
`endif
    endtask

    initial begin
        int extra;

        vecs[0] = '{ops: 64'h00_00_00_FF_00_0F_FF_F0, first: 1'b1, gap: 1'b0, y: 8'hFF};
        vecs[1] = '{ops: 64'hFF_33_33_0F_55_AA_00_00, first: 1'b1, gap: 1'b1, y: 8'h0F};
        vecs[2] = '{ops: 64'hF0_00_81_00_00_00_0F_3C, first: 1'b1, gap: 1'b0, y: 8'h8C};
        vecs[3] = '{ops: 64'hFF_80_01_F0_34_12_0F_AA, first: 1'b0, gap: 1'b0, y: 8'hAB};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_first  = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_state();
        rst = 1'b0;

        // Table-driven frames with immediate consumption
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].ops, vecs[v].first, vecs[v].gap);
            get_result(vecs[v].y);
        end

        // Backpressure: result held for 5 cycles, then taken
        bus.out_ready = 1'b0;
        send_frame(vecs[2].ops, 1'b1, 1'b0);
        get_result(vecs[2].y);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_out_data", bus.out_data, 8'h8C);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
`ifdef LFS_RESULT_COUNT_EN
        exp_count++;
        chk("bp_result_count", result_count, exp_count);
`endif
        chk("bp_taken", bus.out_valid, 0);
        chk("bp_in_ready_after", bus.in_ready, 1);

        // Resync: in_first mid-frame restarts the frame at operand A
        beat(8'h11, 1'b1);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        beat(8'hFF, 1'b1);
        beat(8'hFF, 1'b0);
        chk("resync_frame_err", frame_err, 1);
        beat(8'h00, 1'b0);
        chk("resync_err_pulse_end", frame_err, 0);
        chk("resync_no_early_valid", bus.out_valid, 0);
        for (int i = 0; i < 5; i++) beat(8'h00, 1'b0);
        idle();
        chk("resync_eval_valid", bus.out_valid, 0);
        get_result(8'hFF);
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        chk("resync_single_result", extra, 0);

        // Reset after 5 beats of a frame
        for (int i = 0; i < 5; i++) beat(vecs[0].ops[i*8 +: 8], i == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state();
        send_frame(vecs[1].ops, 1'b0, 1'b0);
        get_result(vecs[1].y);

        // Reset while a result is pending in OUT
        bus.out_ready = 1'b0;
        send_frame(vecs[3].ops, 1'b1, 1'b0);
        @(negedge clk);
        chk("pre_rst_out_valid", bus.out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state();
        bus.out_ready = 1'b1;
        send_frame(vecs[0].ops, 1'b1, 1'b0);
        get_result(vecs[0].y);

`ifdef LFS_RESULT_COUNT_EN
        // Counter wrap: preload near the top, then complete two frames
        force dut.r_result_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_result_count;
        exp_count = 16'hFFFE;
        @(negedge clk);
        chk("count_preload", result_count, exp_count);
        send_frame(vecs[2].ops, 1'b1, 1'b0);
        get_result(vecs[2].y);
        send_frame(vecs[3].ops, 1'b1, 1'b0);
        get_result(vecs[3].y);
        chk("count_wrapped", result_count, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
